// File: rtl/turn_time_ctrl_pkg.sv
// Shared types and widths for the turn timer controller.
// Holds the FSM encoding, BCD digit width, timer count width and a saturating counter helper.
package turn_time_ctrl_pkg;

   localparam int BCD_W = 4;
   localparam int T_W   = 21;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_END   = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/bcd_sec_counter.sv
// Millisecond prescaler feeding a two-digit BCD seconds counter.
// Flags the tick that would make the seconds value reach the turn limit.
module bcd_sec_counter
   import turn_time_ctrl_pkg::*;
#(
   parameter int MS_PER_S = 1000,
   parameter int LIMIT_S  = 10
)
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             clr,
   input  logic             tick,
   input  logic             en,
   input  logic             freeze,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic             lim_hit
);

   localparam int              MS_W     = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
   localparam logic [MS_W-1:0] MS_MAX   = MS_W'(MS_PER_S - 1);
   localparam logic [BCD_W-1:0] LIM_TENS = BCD_W'(LIMIT_S / 10);
   localparam logic [BCD_W-1:0] LIM_ONES = BCD_W'(LIMIT_S % 10);

   logic [MS_W-1:0]  ms_cnt;
   logic [BCD_W-1:0] nxt_tens;
   logic [BCD_W-1:0] nxt_ones;
   logic             sec_carry;
   logic             adv;

   always_comb begin
      nxt_tens = sec_tens;
      nxt_ones = sec_ones + BCD_W'(1);
      if (sec_ones == BCD_W'(9)) begin
         nxt_ones = '0;
         nxt_tens = (sec_tens == BCD_W'(9)) ? '0 : sec_tens + BCD_W'(1);
      end
   end

   assign sec_carry = (ms_cnt == MS_MAX);
   assign adv       = tick & en & ~freeze;
   // Limit match ignores freeze so the owner can decide which event wins.
   assign lim_hit   = tick & en & sec_carry & (nxt_tens == LIM_TENS) & (nxt_ones == LIM_ONES);

   always_ff @(posedge Clk) begin
      if (!Rst || clr) begin
         ms_cnt   <= '0;
         sec_tens <= '0;
         sec_ones <= '0;
      end else if (adv) begin
         if (sec_carry) begin
            ms_cnt   <= '0;
            sec_tens <= nxt_tens;
            sec_ones <= nxt_ones;
         end else begin
            ms_cnt <= ms_cnt + MS_W'(1);
         end
      end
   end

endmodule

// File: rtl/turn_time_ctrl.sv
// Two-player turn timer: starts and clears the upstream ms timer, counts elapsed
// seconds, and reports timeouts or finished turns with per-player timeout tallies.
module turn_time_ctrl
   import turn_time_ctrl_pkg::*;
#(
   parameter int LIMIT_S  = 10,
   parameter int MS_PER_S = 1000
)
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             TurnGo,
   input  logic             Done,
   input  logic [T_W-1:0]   T,
   output logic             TmrStart,
   output logic             TmrRstN,
   output logic             Player,
   output logic             Active,
   output logic [BCD_W-1:0] SecTens,
   output logic [BCD_W-1:0] SecOnes,
   output logic             Timeout,
   output logic             TurnEnd,
   output logic [CNT_W-1:0] ToCnt0,
   output logic [CNT_W-1:0] ToCnt1
);

   state_t         state;
   state_t         state_nxt;
   logic [T_W-1:0] t_q;
   logic           tick;
   logic           lim_hit;
   logic           timeout_nxt;
   logic           turnend_nxt;

   // Any change of the upstream count, including a wrap, is one tick.
   assign tick = (T != t_q);

   bcd_sec_counter #(
      .MS_PER_S (MS_PER_S),
      .LIMIT_S  (LIMIT_S)
   ) u_sec (
      .Clk      (Clk),
      .Rst      (Rst),
      .clr      (state == S_CLEAR),
      .tick     (tick),
      .en       (state == S_RUN),
      .freeze   (Done),
      .sec_tens (SecTens),
      .sec_ones (SecOnes),
      .lim_hit  (lim_hit)
   );

   always_ff @(posedge Clk) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      timeout_nxt = 1'b0;
      turnend_nxt = 1'b0;
      case (state)
         S_IDLE:  if (TurnGo) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_RUN;
         S_RUN: begin
            // Done takes priority over a limit-reaching tick in the same cycle.
            if (Done) begin
               turnend_nxt = 1'b1;
               state_nxt   = S_END;
            end else if (lim_hit) begin
               timeout_nxt = 1'b1;
               state_nxt   = S_END;
            end
         end
         S_END:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         Player   <= 1'b0;
         Active   <= 1'b0;
         TmrStart <= 1'b0;
         TmrRstN  <= 1'b0;
         Timeout  <= 1'b0;
         TurnEnd  <= 1'b0;
         ToCnt0   <= '0;
         ToCnt1   <= '0;
         t_q      <= '0;
      end else begin
         TmrStart <= (state_nxt == S_RUN);
         Active   <= (state_nxt == S_RUN);
         TmrRstN  <= (state_nxt != S_CLEAR);
         Timeout  <= timeout_nxt;
         TurnEnd  <= turnend_nxt;
         t_q      <= (state == S_CLEAR) ? '0 : T;
         if (state == S_END) Player <= ~Player;
         if (timeout_nxt) begin
            if (Player) ToCnt1 <= sat_inc(ToCnt1);
            else        ToCnt0 <= sat_inc(ToCnt0);
         end
      end
   end

endmodule

// File: tb/tb_turn_time_ctrl.sv
// Scoreboard bench for turn_time_ctrl with MS_PER_S=4, LIMIT_S=3.
// Stimulus pushes expected pulse snapshots; a negedge monitor pops and compares them.
module tb_turn_time_ctrl;

   logic        Clk;
   logic        Rst;
   logic        TurnGo;
   logic        Done;
   logic [20:0] T;
   logic        TmrStart;
   logic        TmrRstN;
   logic        Player;
   logic        Active;
   logic [3:0]  SecTens;
   logic [3:0]  SecOnes;
   logic        Timeout;
   logic        TurnEnd;
   logic [3:0]  ToCnt0;
   logic [3:0]  ToCnt1;

   turn_time_ctrl #(
      .LIMIT_S  (3),
      .MS_PER_S (4)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .TurnGo   (TurnGo),
      .Done     (Done),
      .T        (T),
      .TmrStart (TmrStart),
      .TmrRstN  (TmrRstN),
      .Player   (Player),
      .Active   (Active),
      .SecTens  (SecTens),
      .SecOnes  (SecOnes),
      .Timeout  (Timeout),
      .TurnEnd  (TurnEnd),
      .ToCnt0   (ToCnt0),
      .ToCnt1   (ToCnt1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic to;
      logic te;
      logic pl;
      int   tens;
      int   ones;
      int   c0;
      int   c1;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [20:0] tv = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_pulse(input logic to, input logic te, input logic pl,
                               input int tens, input int ones, input int c0, input int c1);
      exp_t e;
      e.to = to; e.te = te; e.pl = pl;
      e.tens = tens; e.ones = ones; e.c0 = c0; e.c1 = c1;
      q.push_back(e);
   endtask

   // Monitor: every Timeout/TurnEnd pulse must match the oldest expectation.
   always @(negedge Clk) begin
      if (Rst && (Timeout || TurnEnd)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: Timeout=%0d TurnEnd=%0d with no pulse expected at %0t",
                     Timeout, TurnEnd, $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_Timeout", Timeout, e.to);
            check("pulse_TurnEnd", TurnEnd, e.te);
            check("pulse_Player",  Player,  e.pl);
            check("pulse_SecTens", SecTens, e.tens);
            check("pulse_SecOnes", SecOnes, e.ones);
            check("pulse_ToCnt0",  ToCnt0,  e.c0);
            check("pulse_ToCnt1",  ToCnt1,  e.c1);
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b0; TurnGo = 1'b0; Done = 1'b0;
      step();
      check("rst_TmrRstN",  TmrRstN,  0);
      check("rst_TmrStart", TmrStart, 0);
      check("rst_Active",   Active,   0);
      check("rst_Player",   Player,   0);
      check("rst_SecTens",  SecTens,  0);
      check("rst_SecOnes",  SecOnes,  0);
      check("rst_Timeout",  Timeout,  0);
      check("rst_TurnEnd",  TurnEnd,  0);
      check("rst_ToCnt0",   ToCnt0,   0);
      check("rst_ToCnt1",   ToCnt1,   0);
      Rst = 1'b1;
      step();
      check("rst_release_TmrRstN", TmrRstN, 1);
   endtask

   task automatic start_turn();
      tv = '0; T = tv; TurnGo = 1'b1;
      step();
      TurnGo = 1'b0;
      check("clear_TmrRstN",  TmrRstN,  0);
      check("clear_TmrStart", TmrStart, 0);
      step();
      check("run_TmrStart", TmrStart, 1);
      check("run_Active",   Active,   1);
      check("run_TmrRstN",  TmrRstN,  1);
      check("run_SecOnes",  SecOnes,  0);
   endtask

   task automatic tick_to(input logic [20:0] v, input int gap, input logic d);
      tv = v; T = tv; Done = d;
      step();
      Done = 1'b0;
      repeat (gap - 1) step();
   endtask

   task automatic ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) tick_to(tv + 21'd1, gap, 1'b0);
   endtask

   initial begin
      Rst = 1'b0; TurnGo = 1'b0; Done = 1'b0; T = '0;

      // Timeout after 12 ticks, T stepping every 3 cycles
      do_reset();
      start_turn();
      expect_pulse(1'b1, 1'b0, 1'b0, 0, 3, 1, 0);
      ticks(12, 3);
      check("to_Player",  Player,  1);
      check("to_Active",  Active,  0);
      check("to_SecOnes", SecOnes, 3);
      check("to_ToCnt0",  ToCnt0,  1);

      // Done after 6 ticks, TurnGo in END and Done in IDLE ignored
      do_reset();
      start_turn();
      ticks(6, 3);
      expect_pulse(1'b0, 1'b1, 1'b0, 0, 1, 0, 0);
      Done = 1'b1;
      step();
      Done = 1'b0; TurnGo = 1'b1;
      step();
      TurnGo = 1'b0;
      check("end_TurnGo_TmrRstN", TmrRstN, 1);
      check("done_Player",  Player,  1);
      ticks(5, 1);
      check("done_SecOnes_held", SecOnes, 1);
      check("done_ToCnt0",  ToCnt0,  0);
      Done = 1'b1;
      step();
      Done = 1'b0;
      step();
      check("idle_Done_TurnEnd", TurnEnd, 0);
      check("idle_Done_Active",  Active,  0);

      // Done on the same cycle as the limit-reaching tick
      do_reset();
      start_turn();
      ticks(11, 3);
      expect_pulse(1'b0, 1'b1, 1'b0, 0, 2, 0, 0);
      tick_to(tv + 21'd1, 1, 1'b1);
      step();
      check("tie_Player",  Player,  1);
      check("tie_SecOnes", SecOnes, 2);
      check("tie_ToCnt0",  ToCnt0,  0);

      // Reset in the middle of a running turn
      do_reset();
      start_turn();
      ticks(5, 2);
      Rst = 1'b0;
      step();
      check("midrst_TmrStart", TmrStart, 0);
      check("midrst_TmrRstN",  TmrRstN,  0);
      check("midrst_Active",   Active,   0);
      check("midrst_SecOnes",  SecOnes,  0);
      check("midrst_Timeout",  Timeout,  0);
      check("midrst_TurnEnd",  TurnEnd,  0);
      Rst = 1'b1;
      step();
      check("midrst_release_TmrRstN", TmrRstN, 1);
      check("midrst_release_Active",  Active,  0);

      // 16 P1 timeouts, P2 turns closed with Done in between
      do_reset();
      for (int i = 0; i < 16; i++) begin
         int c;
         c = (i + 1 > 15) ? 15 : i + 1;
         start_turn();
         expect_pulse(1'b1, 1'b0, 1'b0, 0, 3, c, 0);
         ticks(12, 1);
         step();
         start_turn();
         expect_pulse(1'b0, 1'b1, 1'b1, 0, 0, c, 0);
         Done = 1'b1;
         step();
         Done = 1'b0;
         step();
      end
      check("sat_ToCnt0", ToCnt0, 15);
      check("sat_ToCnt1", ToCnt1, 0);
      check("sat_Player", Player, 0);

      // T wraps 0x1FFFFF -> 0 mid-turn; TurnGo while running is ignored
      do_reset();
      start_turn();
      expect_pulse(1'b1, 1'b0, 1'b0, 0, 3, 1, 0);
      tick_to(21'h1FFFFE, 2, 1'b0);
      tick_to(21'h1FFFFF, 2, 1'b0);
      TurnGo = 1'b1;
      step();
      TurnGo = 1'b0;
      check("run_TurnGo_TmrRstN", TmrRstN, 1);
      check("run_TurnGo_Active",  Active,  1);
      tick_to(21'h000000, 2, 1'b0);
      check("wrap_SecOnes", SecOnes, 0);
      tick_to(21'h000001, 2, 1'b0);
      check("wrap_sec_carry", SecOnes, 1);
      ticks(8, 2);
      check("wrap_Player", Player, 1);
      check("wrap_ToCnt0", ToCnt0, 1);

      step();
      check("pending_pulses", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/turn_time_ctrl.md
TURN_TIME_CTRL -- requirements
Module: turn_time_ctrl

Interface
REQ-001 Parameter LIMIT_S, default 10, turn time limit in whole seconds, legal range 1..99.
REQ-002 Parameter MS_PER_S, default 1000, timer ticks per second; the bench may override it with a small value.
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-low.
REQ-005 TurnGo  input  1  single-cycle pulse that starts a turn for the current player.
REQ-006 Done  input  1  single-cycle pulse: current player finished entering the sequence.
REQ-007 T  input  21  millisecond count from the upstream 1 ms timer.
REQ-008 TmrStart  output  1  enable to the upstream timer.
REQ-009 TmrRstN  output  1  active-low clear to the upstream timer.
REQ-010 Player  output  1  current player: 0 = P1, 1 = P2.
REQ-011 Active  output  1  high while a turn is timing.
REQ-012 SecTens, SecOnes  output  4 each  elapsed seconds of the current turn in BCD.
REQ-013 Timeout  output  1  single-cycle pulse when the limit is reached.
REQ-014 TurnEnd  output  1  single-cycle pulse on Done-terminated turn.
REQ-015 ToCnt0, ToCnt1  output  4 each  per-player timeout counts, saturating at 15.

Function
REQ-016 FSM states are IDLE, CLEAR, RUN, END; all outputs are registered.
REQ-017 IDLE: TmrStart=0, TmrRstN=1, Active=0; TurnGo -> CLEAR; Done ignored.
REQ-018 CLEAR lasts exactly one cycle: TmrRstN=0, TmrStart=0, ms/sec counters zeroed, T_q<=0; next state RUN.
REQ-019 RUN: TmrStart=1, Active=1; TurnGo ignored.
REQ-020 Tick detection: tick=1 when T != T_q; T_q registers T every cycle; a 21-bit wrap counts as one tick.
REQ-021 Each tick increments the internal ms counter; at MS_PER_S-1 the counter wraps to 0 and the BCD seconds increment, with ones 9->0 carrying into tens.
REQ-022 When the incremented seconds value equals LIMIT_S, Timeout pulses for one cycle, ToCnt[Player] increments (saturating at 15), and the FSM moves to END.
REQ-023 Done in RUN: TurnEnd pulses for one cycle, the FSM moves to END, and the seconds value is frozen at its current value.
REQ-024 If Done and the limit-reaching tick occur in the same cycle, Done wins: TurnEnd=1, Timeout=0, no ToCnt change.
REQ-025 END lasts one cycle: TmrStart=0, Active=0, Player toggles, next state IDLE; SecTens/SecOnes hold until the next CLEAR.
REQ-026 TurnGo in END is ignored; a new turn needs a TurnGo in IDLE.
REQ-027 Latency: TurnGo at cycle n gives TmrRstN=0 at n+1 and TmrStart=1 from n+2.

Reset
REQ-028 Rst=0 at a clock edge: state=IDLE, Player=0, Active=0, TmrStart=0, TmrRstN=0, SecTens=SecOnes=0, Timeout=TurnEnd=0, ToCnt0=ToCnt1=0, ms counter=0, T_q=0.
REQ-029 The first cycle after reset release drives TmrRstN=1.
REQ-030 Reset mid-RUN aborts the turn with no Timeout or TurnEnd pulse.

Structure
REQ-031 A shared package holds the FSM state encoding (2 bits), the BCD digit width, and the 21-bit timer count width.
REQ-032 One sub-module, bcd_sec_counter, holds the ms prescaler and 2-digit BCD seconds with synchronous clear, tick enable, freeze, and a limit-match flag.

Verification
REQ-033 The bench shall cover these directed scenarios, each with MS_PER_S=4 and LIMIT_S=3 unless stated otherwise:
- TurnGo, T stepping +1 per 3 cycles -> 12 ticks -> Timeout pulse, SecOnes=3, ToCnt0=1, Player=1.
- TurnGo, Done after 6 ticks -> TurnEnd, SecOnes=1 held, ToCnt0=0, Player=1.
- Done on the same cycle as the 12th tick -> TurnEnd=1, Timeout=0, ToCnt0=0.
- Rst low during RUN -> all outputs at reset values next cycle, no pulses.
- 16 consecutive P1 timeouts -> ToCnt0 saturates at 15; ToCnt1 unchanged.
- T wraps 0x1FFFFF -> 0 during RUN -> counted as one tick; TurnGo in RUN -> ignored.
